// File: rtl/yutorina_bus_arbiter_rr.sv
// Round-robin arbiter for the Yutorina bus.
// Grants one of MASTER_COUNT masters using active-low request/grant vectors.
// A tenure timer forces a handoff once the owner has held the bus for
// MAX_TENURE cycles while someone else is waiting. The owner's lock_ bit
// suppresses that forced handoff. grant_ is decoded from the owner register
// only, so no combinational path runs from request_ to grant_.
module yutorina_bus_arbiter_rr #(
  parameter int MASTER_COUNT = 4,
  parameter int OWNER_WIDTH  = 2,
  parameter int MAX_TENURE   = 16,
  parameter int TIMER_WIDTH  = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MASTER_COUNT-1:0] request_,
  input  logic [MASTER_COUNT-1:0] lock_,
  output logic [MASTER_COUNT-1:0] grant_,
  output logic [OWNER_WIDTH-1:0]  owner,
  output logic                    handover
);

  localparam logic TENURE_LIMITED = (MAX_TENURE != 0);
  // With no tenure limit the timer is held at zero, so its last value is zero.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    (MAX_TENURE == 0) ? {TIMER_WIDTH{1'b0}} : TIMER_WIDTH'(MAX_TENURE - 1);
  localparam logic [OWNER_WIDTH-1:0] OWNER_LAST = OWNER_WIDTH'(MASTER_COUNT - 1);

  logic [OWNER_WIDTH-1:0]  owner_r;
  logic [TIMER_WIDTH-1:0]  timer_r;
  logic                    handover_r;

  logic [MASTER_COUNT-1:0] others_vec_s;
  logic                    own_req_s;
  logic                    others_s;
  logic                    locked_s;
  logic                    expired_s;
  logic                    keep_s;
  logic [TIMER_WIDTH-1:0]  timer_inc_s;

  logic [OWNER_WIDTH-1:0]  cand_s;
  logic [OWNER_WIDTH-1:0]  winner_s;
  logic                    found_s;

  logic [OWNER_WIDTH-1:0]  owner_d_s;
  logic [TIMER_WIDTH-1:0]  timer_d_s;
  logic                    handover_d_s;

  // Work out whether the owner stays: its own request, waiting competitors, lock, tenure expiry.
  always_comb begin
    others_vec_s          = ~request_;
    others_vec_s[owner_r] = 1'b0;
    own_req_s             = ~request_[owner_r];
    others_s              = |others_vec_s;
    locked_s              = ~lock_[owner_r];
    expired_s             = TENURE_LIMITED && (timer_r == TIMER_LAST);
    keep_s                = own_req_s && !(expired_s && others_s && !locked_s);
  end

  // Next tenure count: count up and stop at the last value (or stay at zero when unlimited).
  always_comb begin
    if (!TENURE_LIMITED) begin
      timer_inc_s = {TIMER_WIDTH{1'b0}};
    end else if (timer_r == TIMER_LAST) begin
      timer_inc_s = timer_r;
    end else begin
      timer_inc_s = timer_r + TIMER_WIDTH'(1);
    end
  end

  // Rotational search from owner+1, wrapping modulo MASTER_COUNT (not modulo 2**OWNER_WIDTH).
  always_comb begin
    cand_s   = owner_r;
    winner_s = owner_r;
    found_s  = 1'b0;
    for (int i = 1; i < MASTER_COUNT; i++) begin
      if (cand_s == OWNER_LAST) begin
        cand_s = {OWNER_WIDTH{1'b0}};
      end else begin
        cand_s = cand_s + OWNER_WIDTH'(1);
      end
      if (!found_s && !request_[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Choose between keeping the bus, handing it off, and parking.
  always_comb begin
    owner_d_s    = owner_r;
    timer_d_s    = timer_r;
    handover_d_s = 1'b0;
    if (keep_s) begin
      timer_d_s = timer_inc_s;
    end else if (found_s) begin
      owner_d_s    = winner_s;
      timer_d_s    = {TIMER_WIDTH{1'b0}};
      handover_d_s = 1'b1;
    end else begin
      // Nobody else is waiting: stay parked on the current owner.
      timer_d_s = own_req_s ? timer_inc_s : {TIMER_WIDTH{1'b0}};
    end
  end

  // Arbitration state registers; reset parks the bus on master 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_r    <= {OWNER_WIDTH{1'b0}};
      timer_r    <= {TIMER_WIDTH{1'b0}};
      handover_r <= 1'b0;
    end else begin
      owner_r    <= owner_d_s;
      timer_r    <= timer_d_s;
      handover_r <= handover_d_s;
    end
  end

  // Decode the one-hot active-low grant from the owner register only.
  always_comb begin
    grant_          = {MASTER_COUNT{1'b1}};
    grant_[owner_r] = 1'b0;
  end

  assign owner    = owner_r;
  assign handover = handover_r;

endmodule

// File: tb/tb_yutorina_bus_arbiter_rr.sv
// Directed bench for yutorina_bus_arbiter_rr.
// It drives three instances:
//   dut4 - 4 masters, tenure 4
//   dut0 - 4 masters, unlimited tenure
//   dut3 - 3 masters, for wrap modulo a non-power-of-two
module tb_yutorina_bus_arbiter_rr;

  logic       clock;
  logic       reset;
  logic [3:0] req4, lock4, grant4;
  logic [1:0] owner4;
  logic       ho4;
  logic [3:0] req0, lock0, grant0;
  logic [1:0] owner0;
  logic       ho0;
  logic [2:0] req3, lock3, grant3;
  logic [1:0] owner3;
  logic       ho3;

  int check_cnt = 0;
  int err_cnt   = 0;

  yutorina_bus_arbiter_rr #(
    .MASTER_COUNT(4), .OWNER_WIDTH(2), .MAX_TENURE(4), .TIMER_WIDTH(5)
  ) dut4 (
    .clock(clock), .reset(reset), .request_(req4), .lock_(lock4),
    .grant_(grant4), .owner(owner4), .handover(ho4)
  );

  yutorina_bus_arbiter_rr #(
    .MASTER_COUNT(4), .OWNER_WIDTH(2), .MAX_TENURE(0), .TIMER_WIDTH(5)
  ) dut0 (
    .clock(clock), .reset(reset), .request_(req0), .lock_(lock0),
    .grant_(grant0), .owner(owner0), .handover(ho0)
  );

  yutorina_bus_arbiter_rr #(
    .MASTER_COUNT(3), .OWNER_WIDTH(2), .MAX_TENURE(4), .TIMER_WIDTH(5)
  ) dut3 (
    .clock(clock), .reset(reset), .request_(req3), .lock_(lock3),
    .grant_(grant3), .owner(owner3), .handover(ho3)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then step 1 time unit past it to sample outputs.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req4  = 4'b1111; lock4 = 4'b1111;
    req0  = 4'b1111; lock0 = 4'b1111;
    req3  = 3'b111;  lock3 = 3'b111;

    // 1: reset state, then 10 idle cycles with nothing changing.
    #3;
    check("rst_grant", 32'(grant4), 32'(4'b1110));
    check("rst_owner", 32'(owner4), 32'd0);
    check("rst_ho",    32'(ho4),    32'd0);
    #10;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_grant", 32'(grant4), 32'(4'b1110));
      check("idle_ho",    32'(ho4),    32'd0);
    end

    // 2: a single request from master 2 is granted after one edge.
    req4 = 4'b1011;
    tick();
    check("t2_owner", 32'(owner4), 32'd2);
    check("t2_grant", 32'(grant4), 32'(4'b1011));
    check("t2_ho1",   32'(ho4),    32'd1);
    tick();
    check("t2_ho0",   32'(ho4),    32'd0);
    req4 = 4'b1111;
    tick();
    check("t2_park",  32'(owner4), 32'd2);
    check("t2_parkg", 32'(grant4), 32'(4'b1011));

    // 3: all masters requesting rotates 0,1,2,3,0, four cycles each.
    // Reset first so the sequence starts from owner 0 with a cleared timer.
    reset = 1'b0;
    #1;
    check("t3_rst_owner", 32'(owner4), 32'd0);
    #1;
    reset = 1'b1;
    req4 = 4'b0000;
    req0 = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("t3_owner", 32'(owner4), 32'((k / 4) % 4));
      check("t3_ho",    32'(ho4),    32'((k % 4) == 0));
      check("t5_nolimit_owner", 32'(owner0), 32'd0);
      check("t5_nolimit_ho",    32'(ho0),    32'd0);
    end

    // 4: master 1's lock is ignored while master 0 owns the bus.
    // Once master 1 owns the bus, its lock holds ownership.
    lock4 = 4'b1101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t4_to1", 32'(owner4), (k == 4) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_locked",    32'(owner4), 32'd1);
      check("t4_locked_ho", 32'(ho4),    32'd0);
    end
    lock4 = 4'b1111;
    tick();
    check("t4_unlock_owner", 32'(owner4), 32'd2);
    check("t4_unlock_ho",    32'(ho4),    32'd1);

    // 5: master 3 drops its request while masters 0 and 2 wait.
    // The search wraps, so master 0 wins.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t5_to3", 32'(owner4), (k == 4) ? 32'd3 : 32'd2);
    end
    req4 = 4'b1010;
    tick();
    check("t5_wrap_owner", 32'(owner4), 32'd0);
    check("t5_wrap_grant", 32'(grant4), 32'(4'b1110));
    check("t5_wrap_ho",    32'(ho4),    32'd1);

    // 6: owner 2 at timer=2; an asynchronous reset between edges parks on master 0.
    req4 = 4'b1011;
    tick();
    check("t6_owner2", 32'(owner4), 32'd2);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_owner", 32'(owner4), 32'd0);
    check("t6_async_grant", 32'(grant4), 32'(4'b1110));
    check("t6_async_ho",    32'(ho4),    32'd0);
    #1;
    reset = 1'b1;
    req4 = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t6_timer_restart", 32'(owner4), (k == 4) ? 32'd1 : 32'd0);
    end

    // Three masters: the search from owner 2 must wrap to 0, never reach 3.
    req3 = 3'b011;
    tick();
    check("m3_owner2", 32'(owner3), 32'd2);
    check("m3_ho",     32'(ho3),    32'd1);
    req3 = 3'b110;
    tick();
    check("m3_wrap_owner", 32'(owner3), 32'd0);
    check("m3_wrap_grant", 32'(grant3), 32'(3'b110));

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
